// File: rtl/data_path.sv
// data_path: single-cycle RV32I integer datapath (decode, 32x32 register file, ALU, PC).
// Latency: outputs are combinational from instruction/regfile/PC; state updates on the clk edge.
// Backpressure: none; one instruction is accepted and retired every cycle.
// Optional shifter: define DATAPATH_SHIFT_EN to implement SLL/SRL/SRA and their immediate forms;
// without it every shift encoding decodes as illegal.
module data_path (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_word,
  output logic [31:0] Addition_result,
  output logic [25:0] Control_unit_output,
  output logic [4:0]  A_ADDRESS
);

  // Major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU operation codes carried in the control word
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // Immediate formats
  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  localparam logic [25:0] CTRL_ILLEGAL = 26'h20;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd_fld;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;
  logic       f7_zero;
  logic       f7_alt;

  assign opcode  = instruction_word[6:0];
  assign rd_fld  = instruction_word[11:7];
  assign funct3  = instruction_word[14:12];
  assign rs1     = instruction_word[19:15];
  assign rs2     = instruction_word[24:20];
  assign funct7  = instruction_word[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  // Architectural state
  logic [31:0] pc;
  logic [31:0] regs [32];

  // Raw decode results before the illegal override
  logic [3:0] d_alu_op;
  logic       d_reg_write;
  logic       d_alu_src_imm;
  logic       d_mem_read;
  logic       d_mem_write;
  logic       d_mem_to_reg;
  logic       d_branch;
  logic       d_jal;
  logic       d_jalr;
  logic       d_lui;
  logic       d_auipc;
  logic [2:0] d_imm_sel;
  logic       d_has_rd;
  logic       d_illegal;

  // Decode opcode/funct fields into control flags and flag unsupported encodings
  always_comb begin
    d_alu_op      = ALU_ADD;
    d_reg_write   = 1'b0;
    d_alu_src_imm = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_to_reg  = 1'b0;
    d_branch      = 1'b0;
    d_jal         = 1'b0;
    d_jalr        = 1'b0;
    d_lui         = 1'b0;
    d_auipc       = 1'b0;
    d_imm_sel     = IMM_R;
    d_has_rd      = 1'b0;
    d_illegal     = 1'b0;
    case (opcode)
      OPC_R: begin
        d_reg_write = 1'b1;
        d_has_rd    = 1'b1;
        case (funct3)
          3'b000: begin
            if (f7_zero)     d_alu_op = ALU_ADD;
            else if (f7_alt) d_alu_op = ALU_SUB;
            else             d_illegal = 1'b1;
          end
`ifdef DATAPATH_SHIFT_EN
          3'b001: begin
            d_alu_op  = ALU_SLL;
            d_illegal = !f7_zero;
          end
          3'b101: begin
            if (f7_zero)     d_alu_op = ALU_SRL;
            else if (f7_alt) d_alu_op = ALU_SRA;
            else             d_illegal = 1'b1;
          end
`else
          3'b001:  d_illegal = 1'b1;
          3'b101:  d_illegal = 1'b1;
`endif
          3'b010: begin d_alu_op = ALU_SLT;  d_illegal = !f7_zero; end
          3'b011: begin d_alu_op = ALU_SLTU; d_illegal = !f7_zero; end
          3'b100: begin d_alu_op = ALU_XOR;  d_illegal = !f7_zero; end
          3'b110: begin d_alu_op = ALU_OR;   d_illegal = !f7_zero; end
          default: begin d_alu_op = ALU_AND; d_illegal = !f7_zero; end
        endcase
      end
      OPC_I: begin
        d_reg_write   = 1'b1;
        d_alu_src_imm = 1'b1;
        d_imm_sel     = IMM_I;
        d_has_rd      = 1'b1;
        case (funct3)
          3'b000: d_alu_op = ALU_ADD;
          3'b010: d_alu_op = ALU_SLT;
          3'b011: d_alu_op = ALU_SLTU;
          3'b100: d_alu_op = ALU_XOR;
          3'b110: d_alu_op = ALU_OR;
          3'b111: d_alu_op = ALU_AND;
`ifdef DATAPATH_SHIFT_EN
          3'b001: begin
            d_alu_op  = ALU_SLL;
            d_illegal = !f7_zero;
          end
          default: begin
            if (f7_zero)     d_alu_op = ALU_SRL;
            else if (f7_alt) d_alu_op = ALU_SRA;
            else             d_illegal = 1'b1;
          end
`else
          default: d_illegal = 1'b1;
`endif
        endcase
      end
      OPC_LOAD: begin
        d_reg_write   = 1'b1;
        d_alu_src_imm = 1'b1;
        d_mem_read    = 1'b1;
        d_mem_to_reg  = 1'b1;
        d_imm_sel     = IMM_I;
        d_has_rd      = 1'b1;
        d_illegal     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        d_alu_src_imm = 1'b1;
        d_mem_write   = 1'b1;
        d_imm_sel     = IMM_S;
        d_illegal     = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        d_alu_src_imm = 1'b1;
        d_branch      = 1'b1;
        d_imm_sel     = IMM_B;
        d_illegal     = (funct3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        d_reg_write   = 1'b1;
        d_alu_src_imm = 1'b1;
        d_jal         = 1'b1;
        d_imm_sel     = IMM_J;
        d_has_rd      = 1'b1;
      end
      OPC_JALR: begin
        d_reg_write   = 1'b1;
        d_alu_src_imm = 1'b1;
        d_jalr        = 1'b1;
        d_imm_sel     = IMM_I;
        d_has_rd      = 1'b1;
        d_illegal     = (funct3 != 3'b000);
      end
      OPC_LUI: begin
        d_alu_op      = ALU_PASS_B;
        d_reg_write   = 1'b1;
        d_alu_src_imm = 1'b1;
        d_lui         = 1'b1;
        d_imm_sel     = IMM_U;
        d_has_rd      = 1'b1;
      end
      OPC_AUIPC: begin
        d_reg_write   = 1'b1;
        d_alu_src_imm = 1'b1;
        d_auipc       = 1'b1;
        d_imm_sel     = IMM_U;
        d_has_rd      = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Pack the control word; an illegal encoding collapses it to the lone illegal bit
  logic [25:0] ctrl;
  always_comb begin
    if (d_illegal) begin
      ctrl = CTRL_ILLEGAL;
    end else begin
      ctrl = {d_alu_op, d_reg_write, d_alu_src_imm, d_mem_read, d_mem_write,
              d_mem_to_reg, d_branch, d_jal, d_jalr, d_lui, d_auipc,
              d_imm_sel, funct3, 1'b0, (d_has_rd ? rd_fld : 5'd0)};
    end
  end

  // Everything downstream works from the packed word so illegal ops are inert
  logic [3:0] alu_op;
  logic       reg_write;
  logic       alu_src_imm;
  logic       mem_read;
  logic       branch;
  logic       jal;
  logic       jalr;
  logic       auipc;
  logic [2:0] imm_sel;
  logic [4:0] rd;

  assign alu_op      = ctrl[25:22];
  assign reg_write   = ctrl[21];
  assign alu_src_imm = ctrl[20];
  assign mem_read    = ctrl[19];
  assign branch      = ctrl[16];
  assign jal         = ctrl[15];
  assign jalr        = ctrl[14];
  assign auipc       = ctrl[12];
  assign imm_sel     = ctrl[11:9];
  assign rd          = ctrl[4:0];

  // Immediate generation for each instruction format
  logic [31:0] imm;
  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{20{instruction_word[31]}}, instruction_word[31:20]};
      IMM_S:   imm = {{20{instruction_word[31]}}, instruction_word[31:25], instruction_word[11:7]};
      IMM_B:   imm = {{19{instruction_word[31]}}, instruction_word[31], instruction_word[7],
                      instruction_word[30:25], instruction_word[11:8], 1'b0};
      IMM_U:   imm = {instruction_word[31:12], 12'd0};
      IMM_J:   imm = {{11{instruction_word[31]}}, instruction_word[31], instruction_word[19:12],
                      instruction_word[20], instruction_word[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  // Register reads; x0 is hard-wired to zero
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  // PC-relative ops (AUIPC, JAL, branch target) feed the PC into operand A
  logic [31:0] op_a;
  logic [31:0] op_b;
  assign op_a = (auipc || jal || branch) ? pc : rs1_val;
  assign op_b = alu_src_imm ? imm : rs2_val;

  // 32-bit ALU, all arithmetic wraps modulo 2^32
  logic [31:0] alu_res;
  always_comb begin
    case (alu_op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLT:    alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:   alu_res = {31'd0, (op_a < op_b)};
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_PASS_B: alu_res = op_b;
`ifdef DATAPATH_SHIFT_EN
      ALU_SLL:    alu_res = op_a << op_b[4:0];
      ALU_SRL:    alu_res = op_a >> op_b[4:0];
      ALU_SRA:    alu_res = $signed(op_a) >>> op_b[4:0];
`endif
      default:    alu_res = 32'd0;
    endcase
  end

  // Branch comparator on the raw register operands
  logic cond;
  always_comb begin
    case (funct3)
      3'b000:  cond = (rs1_val == rs2_val);
      3'b001:  cond = (rs1_val != rs2_val);
      3'b100:  cond = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond = (rs1_val < rs2_val);
      3'b111:  cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
  end

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        branch_taken;
  assign pc_plus4     = pc + 32'd4;
  assign branch_taken = branch && cond;
  assign next_pc      = (jal || branch_taken) ? alu_res :
                        jalr                  ? {alu_res[31:1], 1'b0} :
                                                pc_plus4;

  // Loads are written back by the external memory stage, never here
  logic        wr_en;
  logic [31:0] wr_data;
  assign wr_en   = reg_write && !mem_read && (rd != 5'd0);
  assign wr_data = (jal || jalr) ? pc_plus4 : alu_res;

  // Program counter advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'd0;
    else     pc <= next_pc;
  end

  // Register file writeback; reads in the same cycle still see the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wr_en) begin
      regs[rd] <= wr_data;
    end
  end

  assign Addition_result     = alu_res;
  assign Control_unit_output = ctrl;
  assign A_ADDRESS           = rs1;

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_word;
  logic [31:0] Addition_result;
  logic [25:0] Control_unit_output;
  logic [4:0]  A_ADDRESS;

  data_path dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_word    (instruction_word),
    .Addition_result     (Addition_result),
    .Control_unit_output (Control_unit_output),
    .A_ADDRESS           (A_ADDRESS)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: which output, and what it must read
  typedef struct {
    string       tag;
    int          kind;  // 0 result, 1 control word, 2 rs1 address
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_m;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic exp_res(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = 0; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_ctl(input string tag, input logic [25:0] v);
    exp_t e;
    e.tag = tag; e.kind = 1; e.val = {6'd0, v};
    sb.push_back(e);
  endtask

  task automatic exp_ra(input string tag, input logic [4:0] v);
    exp_t e;
    e.tag = tag; e.kind = 2; e.val = {27'd0, v};
    sb.push_back(e);
  endtask

  // Drive an instruction, let the combinational outputs settle, drain the scoreboard
  task automatic drive_check(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] obs;
    instruction_word = ins;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = Addition_result;
        1:       obs = {6'd0, Control_unit_output};
        default: obs = {27'd0, A_ADDRESS};
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Check, then retire the instruction on the next rising edge
  task automatic apply(input logic [31:0] ins);
    drive_check(ins);
    @(posedge clk);
    #1;
    pc_m = pc_m + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x1_m;
    logic [31:0] tgt;
    logic [31:0] link8;
    logic [31:0] link9;

    rst = 1'b1;
    instruction_word = 32'd0;
    pc_m = 32'd0;

    // Under reset: state reads zero, decode still works
    exp_ctl("rst_zero_ins_illegal", 26'h20);
    drive_check(32'h0000_0000);
    exp_res("rst_pc_zero", 32'd0);
    drive_check(enc_u(20'd0, 5'd0, 7'b0010111));
    exp_ctl("rst_andi_ctl", 26'h27003C1);
    drive_check(32'h0010_7093);
    @(posedge clk);
    #1;
    rst = 1'b0;

    exp_res("andi_res", 32'd0);
    exp_ra("andi_ra", 5'd0);
    exp_ctl("andi_ctl", 26'h27003C1);
    apply(32'h0010_7093);
    exp_res("x1_after_andi", 32'd0);
    apply(enc_r(7'd0, 5'd0, 5'd1, 3'b000, 5'd0));

    exp_res("addi_x1_5", 32'd5);
    apply(32'h0050_0093);
    exp_res("add_x2_res", 32'd10);
    exp_ra("add_x2_ra", 5'd1);
    apply(32'h0010_8133);
    exp_res("x2_after_add", 32'd10);
    apply(enc_r(7'd0, 5'd0, 5'd2, 3'b000, 5'd0));

    exp_res("add_x0_res", 32'd5);
    exp_ctl("add_x0_ctl", 26'h0200000);
    apply(32'h0010_0033);
    exp_res("x0_still_zero", 32'd0);
    apply(enc_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011));

    exp_res("sub_res", 32'hFFFF_FFFB);
    apply(32'h4010_0133);
    exp_res("sltu_x0_x2", 32'd1);
    apply(enc_r(7'd0, 5'd2, 5'd0, 3'b011, 5'd3));
    exp_res("slt_x2_x0", 32'd1);
    apply(enc_r(7'd0, 5'd0, 5'd2, 3'b010, 5'd3));
    exp_res("slt_x0_x2", 32'd0);
    apply(enc_r(7'd0, 5'd2, 5'd0, 3'b010, 5'd4));
    exp_res("xori_neg1", 32'hFFFF_FFFA);
    apply(enc_i(12'hFFF, 5'd1, 3'b100, 5'd4, 7'b0010011));
    exp_res("sltiu_neg1", 32'd1);
    apply(enc_i(12'hFFF, 5'd1, 3'b011, 5'd5, 7'b0010011));

    // Illegal word: no write to x31, PC still steps by 4
    exp_ctl("illegal_ctl", 26'h20);
    apply(32'hFFFF_FFFF);
    exp_res("auipc_after_illegal", 32'd56);
    x1_m = pc_m;
    apply(enc_u(20'd0, 5'd1, 7'b0010111));
    exp_res("x31_untouched", 32'd0);
    apply(enc_r(7'd0, 5'd0, 5'd31, 3'b000, 5'd0));
    exp_res("x1_from_auipc", x1_m);
    apply(enc_r(7'd0, 5'd0, 5'd1, 3'b000, 5'd0));

    // Load forms an address but does not write rd here
    exp_res("lw_addr", x1_m + 32'd4);
    exp_ctl("lw_ctl", 26'h03A0286);
    apply(enc_i(12'd4, 5'd1, 3'b010, 5'd6, 7'b0000011));
    exp_res("x6_not_loaded", 32'd0);
    apply(enc_r(7'd0, 5'd0, 5'd6, 3'b000, 5'd0));
    exp_res("sw_addr", x1_m + 32'd8);
    apply(enc_s(12'd8, 5'd2, 5'd1, 3'b010));

    exp_res("lui_res", 32'h1234_5000);
    apply(enc_u(20'h12345, 5'd7, 7'b0110111));
    exp_res("x7_after_lui", 32'h1234_5000);
    apply(enc_r(7'd0, 5'd0, 5'd7, 3'b000, 5'd0));

    // Control flow
    tgt = pc_m + 32'd8;
    exp_res("beq_target", tgt);
    apply(enc_b(13'd8, 5'd0, 5'd0, 3'b000));
    pc_m = tgt;
    exp_res("bne_target", pc_m + 32'd8);
    apply(enc_b(13'd8, 5'd0, 5'd0, 3'b001));
    exp_res("pc_after_bne", pc_m);
    apply(enc_u(20'd0, 5'd0, 7'b0010111));

    tgt   = pc_m + 32'd16;
    link8 = pc_m + 32'd4;
    exp_res("jal_target", tgt);
    apply(enc_j(21'd16, 5'd8));
    pc_m = tgt;
    exp_res("jal_link", link8);
    apply(enc_r(7'd0, 5'd0, 5'd8, 3'b000, 5'd0));

    link9 = pc_m + 32'd4;
    exp_res("jalr_sum", x1_m + 32'd5);
    apply(enc_i(12'd5, 5'd1, 3'b000, 5'd9, 7'b1100111));
    pc_m = (x1_m + 32'd5) & 32'hFFFF_FFFE;
    exp_res("pc_after_jalr", pc_m);
    apply(enc_u(20'd0, 5'd0, 7'b0010111));
    exp_res("jalr_link", link9);
    apply(enc_r(7'd0, 5'd0, 5'd9, 3'b000, 5'd0));

    tgt = pc_m - 32'd16;
    exp_res("blt_target", tgt);
    apply(enc_b(13'h1FF0, 5'd0, 5'd2, 3'b100));
    pc_m = tgt;
    exp_res("pc_after_blt", pc_m);
    apply(enc_u(20'd0, 5'd0, 7'b0010111));

`ifdef DATAPATH_SHIFT_EN
    exp_res("slli_res", x1_m << 2);
    apply(enc_i(12'd2, 5'd1, 3'b001, 5'd10, 7'b0010011));
    exp_res("x10_after_slli", x1_m << 2);
    apply(enc_r(7'd0, 5'd0, 5'd10, 3'b000, 5'd0));
`else
    exp_ctl("slli_illegal", 26'h20);
    apply(enc_i(12'd2, 5'd1, 3'b001, 5'd10, 7'b0010011));
    exp_res("x10_not_written", 32'd0);
    apply(enc_r(7'd0, 5'd0, 5'd10, 3'b000, 5'd0));
`endif

    // Asynchronous reset between edges
    exp_res("addi_x1_again", 32'd5);
    apply(32'h0050_0093);
    exp_res("x1_before_rst", 32'd5);
    apply(enc_r(7'd0, 5'd0, 5'd1, 3'b000, 5'd0));
    #1;
    rst = 1'b1;
    exp_res("x1_async_rst", 32'd0);
    drive_check(enc_r(7'd0, 5'd0, 5'd1, 3'b000, 5'd0));
    exp_res("pc_async_rst", 32'd0);
    drive_check(enc_u(20'd0, 5'd0, 7'b0010111));
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
